regfile_sb: RTL and testbench

- Parametrised multi-register file that generalises the single 32-bit, two-read-port register into DEPTH words of WIDTH bits.
- One synchronous write port and two combinational read ports; reads use a mux, not tri-state buses.
- Adds a per-register busy scoreboard: a destination is reserved at issue and released at writeback, so the decode stage can detect RAW hazards.
- Sits between the decode and writeback stages of the processor pipeline.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_sb_reg_word.sv | 48 ++++
 rtl/regfile_sb.sv | 99 +++++++++
 tb/tb_regfile_sb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Used by the register file, decode and the hazard unit.
package regfile_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 32;

    // Address bits needed to index depth registers (never less than 1).
    function automatic int unsigned addr_width(input int unsigned depth);
        if (depth <= 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_sb_reg_word.sv
// One register of the file: WIDTH data bits plus its busy (reservation) flop.
// Ports:
//   clk      rising-edge clock
//   clr      asynchronous active-high clear of data and busy
//   i_we     write this word (already address-decoded)
//   i_wdata  write data
//   i_rsv    reserve this word (already address-decoded)
//   o_data   stored data
//   o_busy   reservation outstanding
module reg_word #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rsv,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy
);

    logic [WIDTH-1:0] r_data;
    logic             r_busy;

    // Data storage.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_data <= '0;
        end else if (i_we) begin
            r_data <= i_wdata;
        end
    end

    // Busy flag: a new reservation wins over a writeback in the same cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_busy <= 1'b0;
        end else if (i_rsv) begin
            r_busy <= 1'b1;
        end else if (i_we) begin
            r_busy <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard for RAW
// hazard detection between decode and writeback.
// Optional macro REGFILE_WRITE_BYPASS_EN: forwards writeback data to a read
// port addressing the word being written in the same cycle.
// Ports:
//   clk                  rising-edge clock
//   clr                  asynchronous active-high clear
//   we, waddr, wdata     writeback port
//   rsv_en, rsv_addr     reserve (mark busy) a destination at issue
//   raddr_a, raddr_b     combinational read addresses
//   rdata_a, rdata_b     read data
//   busy_a, busy_b       reservation outstanding on the addressed register
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter  int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy_a,
    output logic             busy_b
);

    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_busy [DEPTH];

    // Storage words with their write/reserve decoders; word 0 is hardwired
    // to zero and never busy when ZERO_REG is set.
    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign w_data[i] = '0;
            assign w_busy[i] = 1'b0;
        end else begin : g_reg
            logic w_we;
            logic w_rsv;
            assign w_we  = we     && (waddr    == AW'(i));
            assign w_rsv = rsv_en && (rsv_addr == AW'(i));
            reg_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clk     (clk),
                .clr     (clr),
                .i_we    (w_we),
                .i_wdata (wdata),
                .i_rsv   (w_rsv),
                .o_data  (w_data[i]),
                .o_busy  (w_busy[i])
            );
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic w_wr_live;
    // A write to a suppressed register 0 is not forwarded.
    assign w_wr_live = we && !((ZERO_REG != 0) && (waddr == '0));
`endif

    // Read port A mux.
    always_comb begin
        rdata_a = w_data[raddr_a];
        busy_a  = w_busy[raddr_a];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_wr_live && (raddr_a == waddr)) begin
            rdata_a = wdata;
            // A same-cycle reservation keeps the stored busy view.
            if (!(rsv_en && (rsv_addr == raddr_a))) begin
                busy_a = 1'b0;
            end
        end
`endif
    end

    // Read port B mux.
    always_comb begin
        rdata_b = w_data[raddr_b];
        busy_b  = w_busy[raddr_b];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (w_wr_live && (raddr_b == waddr)) begin
            rdata_b = wdata;
            if (!(rsv_en && (rsv_addr == raddr_b))) begin
                busy_b = 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb (WIDTH=32, DEPTH=32, ZERO_REG=1).
module tb_regfile_sb;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        clr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        busy_a;
    logic        busy_b;

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [31:0] b;
        logic        ba;
        logic        bb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_sb #(
        .WIDTH    (32),
        .DEPTH    (32),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .busy_a   (busy_a),
        .busy_b   (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: whenever an expectation is pending, sample the outputs and compare.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() > 0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (rdata_a !== e.a) begin
                errors++;
                $display("FAIL %s rdata_a: got %h expected %h", e.nm, rdata_a, e.a);
            end
            checks++;
            if (rdata_b !== e.b) begin
                errors++;
                $display("FAIL %s rdata_b: got %h expected %h", e.nm, rdata_b, e.b);
            end
            checks++;
            if (busy_a !== e.ba) begin
                errors++;
                $display("FAIL %s busy_a: got %b expected %b", e.nm, busy_a, e.ba);
            end
            checks++;
            if (busy_b !== e.bb) begin
                errors++;
                $display("FAIL %s busy_b: got %b expected %b", e.nm, busy_b, e.bb);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic [4:0] wa, input logic [31:0] wd,
                         input bit rv, input logic [4:0] rva,
                         input logic [4:0] ra, input logic [4:0] rb);
        we       = w;
        waddr    = wa;
        wdata    = wd;
        rsv_en   = rv;
        rsv_addr = rva;
        raddr_a  = ra;
        raddr_b  = rb;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input logic ba, input logic bb);
        exp_t e;
        e.nm = nm;
        e.a  = a;
        e.b  = b;
        e.ba = ba;
        e.bb = bb;
        exp_q.push_back(e);
        #3;
    endtask

    initial begin
        int budget;
        clr = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        tick();
        expect_out("reset_hold", 32'h0, 32'h0, 1'b0, 1'b0);
        clr = 1'b0;
        tick();

        // Write reg5 and reserve it, then clear between edges.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd5, 5'd5);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
        expect_out("pre_clr", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        expect_out("clr_async", 32'h0, 32'h0, 1'b0, 1'b0);
        clr = 1'b0;
        tick();
        expect_out("post_clr", 32'h0, 32'h0, 1'b0, 1'b0);

        // Clear on the same edge as a write/reserve discards them.
        drive(1'b1, 5'd6, 32'h11112222, 1'b1, 5'd6, 5'd6, 5'd6);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd6);
        expect_out("clr_dominates", 32'h0, 32'h0, 1'b0, 1'b0);

        // Basic write, read next cycle on both ports.
        drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd1, 5'd2);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        expect_out("write_read", 32'h12345678, 32'h12345678, 1'b0, 1'b0);

        // Register 0: write and reserve both ignored, also in the issue cycle.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        expect_out("zero_same_cycle", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        expect_out("zero_reg", 32'h0, 32'h0, 1'b0, 1'b0);

        // Scoreboard: reserve reg3, then writeback releases it.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7, 5'd3);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3);
        expect_out("rsv3", 32'h12345678, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 5'd3, 32'h000000A5, 1'b0, 5'd0, 5'd7, 5'd3);
        expect_out("wb3_same_cycle", 32'h12345678, BYP ? 32'hA5 : 32'h0, 1'b0, BYP ? 1'b0 : 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3);
        expect_out("wb3", 32'h12345678, 32'h000000A5, 1'b0, 1'b0);

        // Reserve and writeback to reg9 in one cycle: data written, busy set.
        drive(1'b1, 5'd9, 32'h00000055, 1'b1, 5'd9, 5'd9, 5'd3);
        expect_out("sim9_same_cycle", BYP ? 32'h55 : 32'h0, 32'hA5, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        expect_out("sim9", 32'h00000055, 32'h00000055, 1'b1, 1'b1);

        // Re-reserve an already-busy register; one writeback still clears it.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        expect_out("rsv9_again", 32'h00000055, 32'h00000055, 1'b1, 1'b1);
        drive(1'b1, 5'd9, 32'h00000066, 1'b0, 5'd0, 5'd9, 5'd9);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        expect_out("wb9", 32'h00000066, 32'h00000066, 1'b0, 1'b0);

        // Same-cycle read of a word being written.
        drive(1'b1, 5'd4, 32'h00000011, 1'b0, 5'd0, 5'd4, 5'd4);
        tick();
        drive(1'b1, 5'd4, 32'h00000077, 1'b0, 5'd0, 5'd4, 5'd7);
        expect_out("bypass4_same", BYP ? 32'h77 : 32'h11, 32'h12345678, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd7);
        expect_out("bypass4_next", 32'h00000077, 32'h12345678, 1'b0, 1'b0);

        // Top addresses: write reg31 and reserve reg30 together.
        drive(1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd30, 5'd31, 5'd30);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd30);
        expect_out("top_addr", 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);

        // Let the monitor drain, bounded.
        budget = 100;
        while (exp_q.size() > 0 && budget > 0) begin
            #1;
            budget--;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
